// File: rtl/b_mux4_scan.sv
// Scan sequencer around a 4:1 mux: steps the select, samples y once per
// select value and hands the packed 4-bit word downstream on valid/ready.
module b_mux4_scan #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       y,
  output logic [1:0] s,
  output logic       busy,
  output logic [3:0] word,
  output logic       word_valid,
  input  logic       word_ready
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_s;
  logic [3:0] r_cnt;
  logic [2:0] r_sh;
  logic [3:0] r_word;
  logic       r_word_valid;
  logic       r_busy;
  logic       w_capture;

  assign w_capture = (r_cnt == SETTLE_C);

  // Shift register fills from the top so sample k lands in r_sh[k] after bit 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_s          <= 2'd0;
      r_cnt        <= 4'd0;
      r_sh         <= 3'd0;
      r_word       <= 4'd0;
      r_word_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_s <= 2'd0;
          if (start) begin
            r_state <= ST_SCAN;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (w_capture) begin
            r_cnt <= 4'd0;
            r_s   <= r_s + 2'd1;
            if (r_s == 2'd3) begin
              r_word       <= {y, r_sh};
              r_word_valid <= 1'b1;
              r_state      <= ST_HOLD;
            end else begin
              r_sh <= {y, r_sh[2:1]};
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_HOLD: begin
          r_s <= 2'd0;
          if (r_word_valid && word_ready) begin
            r_word_valid <= 1'b0;
            r_cnt        <= 4'd0;
            if (cont) begin
              r_state <= ST_SCAN;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s          = r_s;
  assign busy       = r_busy;
  assign word       = r_word;
  assign word_valid = r_word_valid;

endmodule

// File: tb/tb_b_mux4_scan.sv
// Directed bench for b_mux4_scan at SETTLE=1, 0 and 15 with a behavioural mux.
`timescale 1ns/1ps
module tb_b_mux4_scan;

  logic       clk = 1'b0;
  logic       rst_n, start, cont, word_ready;
  logic [3:0] i;

  logic       y1, y0, y15;
  logic [1:0] s1, s0, s15;
  logic       busy1, busy0, busy15;
  logic [3:0] word1, word0, word15;
  logic       v1, v0, v15;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural 4:1 mux, combinational from the select
  assign y1  = i[s1];
  assign y0  = i[s0];
  assign y15 = i[s15];

  b_mux4_scan #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .y(y1), .s(s1),
    .busy(busy1), .word(word1), .word_valid(v1), .word_ready(word_ready));

  b_mux4_scan #(.SETTLE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .y(y0), .s(s0),
    .busy(busy0), .word(word0), .word_valid(v0), .word_ready(word_ready));

  b_mux4_scan #(.SETTLE(15)) u15 (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .y(y15), .s(s15),
    .busy(busy15), .word(word15), .word_valid(v15), .word_ready(word_ready));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; cont = 1'b0; word_ready = 1'b1; i = 4'b1010;

    // Reset with start held high
    step(); step();
    chk("rst_s",    32'(s1), 32'd0);
    chk("rst_word", 32'(word1), 32'd0);
    chk("rst_vld",  32'(v1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_busy15", 32'(busy15), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    step();
    chk("idle_busy", 32'(busy1), 32'd0);

    // Single scan, SETTLE=1
    i = 4'b1010; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("scan_s",    32'(s1), 32'(k / 2));
      chk("scan_vld",  32'(v1), 32'd0);
      chk("scan_busy", 32'(busy1), 32'd1);
      step();
    end
    chk("scan_vld_rise", 32'(v1), 32'd1);
    chk("scan_word",     32'(word1), 32'b1010);
    chk("scan_hold_s",   32'(s1), 32'd0);
    step();
    chk("scan_xfer_vld",  32'(v1), 32'd0);
    chk("scan_xfer_busy", 32'(busy1), 32'd0);
    chk("scan_word_kept", 32'(word1), 32'b1010);

    // Back-pressure
    i = 4'b0110; word_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("bp_vld",  32'(v1), 32'd1);
    chk("bp_word", 32'(word1), 32'b0110);
    for (int k = 0; k < 10; k++) begin
      start = (k == 4);
      step();
      chk("bp_hold_vld",  32'(v1), 32'd1);
      chk("bp_hold_word", 32'(word1), 32'b0110);
      chk("bp_hold_busy", 32'(busy1), 32'd1);
      chk("bp_hold_s",    32'(s1), 32'd0);
    end
    start = 1'b0; word_ready = 1'b1;
    step();
    chk("bp_xfer_vld",  32'(v1), 32'd0);
    chk("bp_xfer_busy", 32'(busy1), 32'd0);
    step();
    chk("bp_no_queue_busy", 32'(busy1), 32'd0);
    chk("bp_no_queue_vld",  32'(v1), 32'd0);

    // Continuous mode, SETTLE=0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; cont = 1'b1; word_ready = 1'b1; i = 4'h3; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("cont1_s",   32'(s0), 32'(k));
      chk("cont1_vld", 32'(v0), 32'd0);
      step();
    end
    chk("cont1_vld_rise", 32'(v0), 32'd1);
    chk("cont1_word",     32'(word0), 32'h3);
    chk("cont1_wrap_s",   32'(s0), 32'd0);
    i = 4'hC;
    step();
    chk("cont_xfer_vld",  32'(v0), 32'd0);
    chk("cont_xfer_busy", 32'(busy0), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("cont2_s",   32'(s0), 32'(k));
      chk("cont2_vld", 32'(v0), 32'd0);
      step();
    end
    chk("cont2_vld_rise", 32'(v0), 32'd1);
    chk("cont2_word",     32'(word0), 32'hC);
    cont = 1'b0;
    step();
    chk("cont_end_vld",  32'(v0), 32'd0);
    chk("cont_end_busy", 32'(busy0), 32'd0);

    // Reset mid-scan, SETTLE=1
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; i = 4'b0101; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mid_pre_s", 32'(s1), 32'd2);
    rst_n = 1'b0;
    step();
    chk("mid_rst_s",    32'(s1), 32'd0);
    chk("mid_rst_vld",  32'(v1), 32'd0);
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_word", 32'(word1), 32'd0);
    rst_n = 1'b1; i = 4'b0110; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("mid_new_vld",  32'(v1), 32'd1);
    chk("mid_new_word", 32'(word1), 32'b0110);

    // Settle extreme, SETTLE=15
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; i = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      chk("s15_s",   32'(s15), 32'(k / 16));
      chk("s15_vld", 32'(v15), 32'd0);
      step();
    end
    chk("s15_vld_rise", 32'(v15), 32'd1);
    chk("s15_word",     32'(word15), 32'hF);
    step();
    chk("s15_xfer_vld", 32'(v15), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
